vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 3, giving the number of CPU-side requester channels (legal range 1-8).
REQ-002 The block SHALL have parameter ADDR_W, default 16, giving the VRAM address width.
REQ-003 The block SHALL have parameter DATA_W, default 8, giving the VRAM data width.
REQ-004 The block SHALL have parameter STARVE_LIMIT, default 341, giving the starvation threshold in cycles.
REQ-005 The block SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, width 1: asynchronous, active-low reset.
REQ-007 The block SHALL have port render_active, input, width 1: 1 = the renderer owns VRAM.
REQ-008 The block SHALL have port rnd_addr, input, width ADDR_W: the renderer fetch address.
REQ-009 The block SHALL have port req, input, width NUM_CH: per-channel access request.
REQ-010 The block SHALL have port we, input, width NUM_CH: per-channel write (1) or read (0).
REQ-011 The block SHALL have port addr, input, width NUM_CH*ADDR_W: packed per-channel addresses, channel 0 in the LSBs.
REQ-012 The block SHALL have port wdata, input, width NUM_CH*DATA_W: packed per-channel write data.
REQ-013 The block SHALL have port gnt, output, width NUM_CH: one-hot grant.
REQ-014 The block SHALL have port rvalid, output, width NUM_CH: read data valid for that channel.
REQ-015 The block SHALL have port rdata, output, width DATA_W: shared read data, qualified by rvalid.
REQ-016 The block SHALL have ports mem_addr (output, ADDR_W), mem_we (output, 1), mem_wdata (output, DATA_W) and mem_rdata (input, DATA_W) connecting to the synchronous VRAM, which has 1-cycle read latency.
REQ-017 The block SHALL have port starve_err, output, width 1: sticky starvation flag.

Function
REQ-018 While render_active=1, the block SHALL drive gnt=0, mem_addr=rnd_addr and mem_we=0 in the same cycle, with no register stage.
REQ-019 While render_active=0, the block SHALL grant at most one requesting channel per cycle, combinationally in the same cycle, searching round-robin from rr_ptr upward modulo NUM_CH.
REQ-020 In a granted cycle, mem_addr, mem_we and mem_wdata SHALL equal the granted channel's addr, we and wdata fields.
REQ-021 After each grant, rr_ptr SHALL become (granted index + 1) mod NUM_CH; rr_ptr SHALL hold when nothing is granted.
REQ-022 A channel SHALL hold req, we, addr and wdata stable until gnt; each gnt cycle is exactly one transfer, and req still high on the following cycle is a new request.
REQ-023 For a read grant in cycle N, rvalid[ch] SHALL be 1 in cycle N+1 only, with rdata=mem_rdata; a write grant SHALL produce no rvalid.
REQ-024 A read granted in the last cycle before render_active rises SHALL still return rvalid in the next cycle.
REQ-025 When no channel requests and render_active=0, mem_we SHALL be 0 and mem_addr SHALL be 0.
REQ-026 When NUM_CH=1, rr_ptr SHALL be a constant 0 and the single channel SHALL be granted whenever req=1 and render_active=0.

Reset
REQ-027 While reset=0, the block SHALL force gnt=0, rvalid=0, mem_we=0, rr_ptr=0, all starvation counters=0 and starve_err=0.
REQ-028 A read granted in the cycle reset asserts SHALL be discarded, producing no rvalid after reset release.
REQ-029 The first grant after reset release SHALL start the round-robin search from channel 0.

Configuration
REQ-030 With macro VRAM_ARB_STARVE_EN defined, the block SHALL keep one counter per channel that increments each cycle the channel has req=1 and gnt=0, and clears on grant or when req=0.
REQ-031 With VRAM_ARB_STARVE_EN defined, starve_err SHALL set when any counter reaches STARVE_LIMIT and SHALL stay set until reset.
REQ-032 With VRAM_ARB_STARVE_EN undefined, the block SHALL contain no counters and SHALL tie starve_err to 0.

Verification
REQ-033 The bench SHALL cover: NUM_CH=3, req=3'b111 held, render_active=0 -> gnt sequence 001, 010, 100, 001 on consecutive cycles.
REQ-034 The bench SHALL cover: ch1 read addr 0x2005 with mem_rdata=0x5A -> gnt[1] in cycle N, rvalid=3'b010 and rdata=0x5A in cycle N+1, rvalid=0 in N+2.
REQ-035 The bench SHALL cover: render_active=1, rnd_addr=0x23C0, req=3'b101 -> gnt=0 and mem_addr=0x23C0; when render_active falls, gnt=001 in that same cycle.
REQ-036 The bench SHALL cover: ch0 write 0x3F00/0x0F -> mem_we=1, mem_addr=0x3F00, mem_wdata=0x0F for one cycle, and no rvalid.
REQ-037 The bench SHALL cover: VRAM_ARB_STARVE_EN with STARVE_LIMIT=4 and render_active held at 1 with req[2]=1 -> starve_err=1 after the 4th blocked cycle, staying 1 until reset=0.
REQ-038 The bench SHALL cover: reset asserted in the cycle of a read grant -> no rvalid after release, and the first grant goes to channel 0.

Source files
------------

// File: rtl/vram_arbiter.sv
// Round-robin VRAM arbiter: the renderer has absolute priority, CPU channels share the remaining cycles.
// Optional per-channel starvation monitor enabled by defining VRAM_ARB_STARVE_EN.
module vram_arbiter #(
    parameter int NUM_CH       = 3,
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 341
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     render_active,
    input  logic [ADDR_W-1:0]        rnd_addr,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        we,
    input  logic [NUM_CH*ADDR_W-1:0] addr,
    input  logic [NUM_CH*DATA_W-1:0] wdata,
    output logic [NUM_CH-1:0]        gnt,
    output logic [NUM_CH-1:0]        rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_we,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     starve_err
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [ADDR_W-1:0] addr_a_s  [NUM_CH];
    logic [DATA_W-1:0] wdata_a_s [NUM_CH];
    logic [PTR_W-1:0]  rr_ptr_r;
    logic [PTR_W-1:0]  cand_s;
    logic [PTR_W-1:0]  pick_idx_s;
    logic [PTR_W-1:0]  ptr_next_s;
    logic              pick_s;
    logic              grant_en_s;
    logic [NUM_CH-1:0] gnt_s;
    logic [NUM_CH-1:0] rvalid_r;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign addr_a_s[g]  = addr[g*ADDR_W +: ADDR_W];
        assign wdata_a_s[g] = wdata[g*DATA_W +: DATA_W];
    end

    // Search for the first requester starting at rr_ptr and wrapping modulo NUM_CH
    always_comb begin
        pick_s     = 1'b0;
        pick_idx_s = '0;
        cand_s     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand_s = PTR_W'((int'(rr_ptr_r) + i) % NUM_CH);
            if (!pick_s && req[cand_s]) begin
                pick_s     = 1'b1;
                pick_idx_s = cand_s;
            end else begin
                pick_s     = pick_s;
            end
        end
    end

    // Reset (active low) and the renderer both suppress CPU grants in the same cycle
    assign grant_en_s = reset & ~render_active & pick_s;
    assign ptr_next_s = (pick_idx_s == PTR_W'(NUM_CH - 1)) ? '0 : pick_idx_s + PTR_W'(1);

    // One-hot grant decode
    always_comb begin
        gnt_s = '0;
        if (grant_en_s) begin
            gnt_s[pick_idx_s] = 1'b1;
        end else begin
            gnt_s = '0;
        end
    end

    // VRAM port mux: renderer address, granted channel, or idle zeros
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (render_active) begin
            mem_addr  = rnd_addr;
            mem_we    = 1'b0;
            mem_wdata = '0;
        end else if (grant_en_s) begin
            mem_addr  = addr_a_s[pick_idx_s];
            mem_we    = we[pick_idx_s];
            mem_wdata = wdata_a_s[pick_idx_s];
        end else begin
            mem_addr  = '0;
            mem_we    = 1'b0;
            mem_wdata = '0;
        end
    end

    if (NUM_CH == 1) begin : g_single
        assign rr_ptr_r = '0;
    end else begin : g_multi
        // Round-robin pointer advances past the winner, holds when idle
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rr_ptr_r <= '0;
            end else if (grant_en_s) begin
                rr_ptr_r <= ptr_next_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Read-return tracker: the VRAM answers one cycle after the read grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid_r <= '0;
        end else begin
            rvalid_r <= gnt_s & ~we;
        end
    end

    assign gnt    = gnt_s;
    assign rvalid = rvalid_r;
    assign rdata  = mem_rdata;

`ifdef VRAM_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_r [NUM_CH];
    logic             starve_err_r;
    logic             starve_hit_s;

    // Flag when any waiting channel is about to reach the limit on this edge
    always_comb begin
        starve_hit_s = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req[i] && !gnt_s[i] && (starve_cnt_r[i] >= CNT_W'(STARVE_LIMIT - 1))) begin
                starve_hit_s = 1'b1;
            end else begin
                starve_hit_s = starve_hit_s;
            end
        end
    end

    // Per-channel wait counters (saturating) and the sticky error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                starve_cnt_r[i] <= '0;
            end
            starve_err_r <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (req[i] && !gnt_s[i]) begin
                    if (starve_cnt_r[i] != CNT_W'(STARVE_LIMIT)) begin
                        starve_cnt_r[i] <= starve_cnt_r[i] + CNT_W'(1);
                    end else begin
                        starve_cnt_r[i] <= starve_cnt_r[i];
                    end
                end else begin
                    starve_cnt_r[i] <= '0;
                end
            end
            starve_err_r <= starve_err_r | starve_hit_s;
        end
    end

    assign starve_err = starve_err_r;
`else
    assign starve_err = 1'b0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: round-robin order, read return, renderer priority,
// writes, starvation flag and reset behaviour.
module tb_vram_arbiter;

    localparam int NUM_CH = 3;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    logic                     clk;
    logic                     reset;
    logic                     render_active;
    logic [ADDR_W-1:0]        rnd_addr;
    logic [NUM_CH-1:0]        req;
    logic [NUM_CH-1:0]        we;
    logic [NUM_CH*ADDR_W-1:0] addr;
    logic [NUM_CH*DATA_W-1:0] wdata;
    logic [NUM_CH-1:0]        gnt;
    logic [NUM_CH-1:0]        rvalid;
    logic [DATA_W-1:0]        rdata;
    logic [ADDR_W-1:0]        mem_addr;
    logic                     mem_we;
    logic [DATA_W-1:0]        mem_wdata;
    logic [DATA_W-1:0]        mem_rdata;
    logic                     starve_err;

    int n_checks;
    int n_fail;
    logic exp_starve;

    vram_arbiter #(
        .NUM_CH      (NUM_CH),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .render_active(render_active),
        .rnd_addr     (rnd_addr),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .gnt          (gnt),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .starve_err   (starve_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
`ifdef VRAM_ARB_STARVE_EN
        exp_starve = 1'b1;
`else
        exp_starve = 1'b0;
`endif
        reset         = 1'b0;
        render_active = 1'b0;
        rnd_addr      = 16'h0000;
        req           = 3'b111;
        we            = 3'b000;
        addr          = {16'h0300, 16'h0200, 16'h0100};
        wdata         = {8'h33, 8'h22, 8'h11};
        mem_rdata     = 8'h5A;
        #1;
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_mem_we", 32'(mem_we), 32'h0);
        chk("reset_rvalid", 32'(rvalid), 32'h0);
        chk("reset_starve", 32'(starve_err), 32'h0);

        // Round-robin with all three requesting
        @(negedge clk); reset = 1'b1; #1;
        chk("rr_gnt0", 32'(gnt), 32'h1);
        chk("rr_rvalid0", 32'(rvalid), 32'h0);
        @(negedge clk); #1;
        chk("rr_gnt1", 32'(gnt), 32'h2);
        chk("rr_rvalid1", 32'(rvalid), 32'h1);
        @(negedge clk); #1;
        chk("rr_gnt2", 32'(gnt), 32'h4);
        chk("rr_rvalid2", 32'(rvalid), 32'h2);
        @(negedge clk); #1;
        chk("rr_gnt3", 32'(gnt), 32'h1);
        chk("rr_rvalid3", 32'(rvalid), 32'h4);

        // Idle: no grant, zero address, no write
        @(negedge clk); req = 3'b000; #1;
        chk("idle_gnt", 32'(gnt), 32'h0);
        chk("idle_mem_addr", 32'(mem_addr), 32'h0);
        chk("idle_mem_we", 32'(mem_we), 32'h0);
        chk("idle_rvalid", 32'(rvalid), 32'h1);

        // Channel 1 read from 0x2005
        @(negedge clk); req = 3'b010; addr[31:16] = 16'h2005; #1;
        chk("rd_gnt", 32'(gnt), 32'h2);
        chk("rd_mem_addr", 32'(mem_addr), 32'h2005);
        chk("rd_mem_we", 32'(mem_we), 32'h0);
        @(negedge clk); req = 3'b000; #1;
        chk("rd_rvalid", 32'(rvalid), 32'h2);
        chk("rd_rdata", 32'(rdata), 32'h5A);
        @(negedge clk); #1;
        chk("rd_rvalid_gone", 32'(rvalid), 32'h0);

        // Channel 0 write 0x0F to 0x3F00
        @(negedge clk); req = 3'b001; we = 3'b001; addr[15:0] = 16'h3F00; wdata[7:0] = 8'h0F; #1;
        chk("wr_gnt", 32'(gnt), 32'h1);
        chk("wr_mem_we", 32'(mem_we), 32'h1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h3F00);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'h0F);
        @(negedge clk); req = 3'b000; we = 3'b000; #1;
        chk("wr_no_rvalid", 32'(rvalid), 32'h0);
        chk("wr_mem_we_off", 32'(mem_we), 32'h0);

        // Channel 2 read right before the renderer takes over
        @(negedge clk); req = 3'b100; addr[47:32] = 16'h1234; #1;
        chk("pre_rnd_gnt", 32'(gnt), 32'h4);
        chk("pre_rnd_mem_addr", 32'(mem_addr), 32'h1234);
        @(negedge clk); render_active = 1'b1; rnd_addr = 16'h23C0; req = 3'b101; #1;
        chk("rnd_gnt", 32'(gnt), 32'h0);
        chk("rnd_mem_addr", 32'(mem_addr), 32'h23C0);
        chk("rnd_mem_we", 32'(mem_we), 32'h0);
        chk("rnd_late_rvalid", 32'(rvalid), 32'h4);
        @(negedge clk); #1;
        chk("rnd_gnt_hold", 32'(gnt), 32'h0);
        chk("rnd_rvalid_gone", 32'(rvalid), 32'h0);
        @(negedge clk); render_active = 1'b0; #1;
        chk("rnd_fall_gnt", 32'(gnt), 32'h1);
        chk("rnd_fall_mem_addr", 32'(mem_addr), 32'h3F00);
        @(negedge clk); req = 3'b100; #1;
        chk("post_rnd_gnt", 32'(gnt), 32'h4);
        chk("post_rnd_rvalid", 32'(rvalid), 32'h1);

        // Starvation: channel 2 blocked by the renderer
        @(negedge clk); render_active = 1'b1; #1;
        chk("starve_b1", 32'(starve_err), 32'h0);
        @(negedge clk); #1;
        chk("starve_b2", 32'(starve_err), 32'h0);
        @(negedge clk); #1;
        chk("starve_b3", 32'(starve_err), 32'h0);
        @(negedge clk); #1;
        chk("starve_b4", 32'(starve_err), 32'h0);
        @(negedge clk); #1;
        chk("starve_set", 32'(starve_err), 32'(exp_starve));
        @(negedge clk); render_active = 1'b0; req = 3'b000; #1;
        chk("starve_sticky", 32'(starve_err), 32'(exp_starve));

        // Reset lands in the cycle of a channel 1 read grant
        @(negedge clk); req = 3'b001; #1;
        chk("pre_rst_gnt0", 32'(gnt), 32'h1);
        @(negedge clk); req = 3'b010; #1;
        chk("pre_rst_gnt1", 32'(gnt), 32'h2);
        #2; reset = 1'b0; #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_starve", 32'(starve_err), 32'h0);
        @(negedge clk); reset = 1'b1; req = 3'b101; #1;
        chk("post_rst_rvalid", 32'(rvalid), 32'h0);
        chk("post_rst_gnt", 32'(gnt), 32'h1);
        @(negedge clk); req = 3'b000; #1;
        chk("post_rst_rvalid2", 32'(rvalid), 32'h1);
        chk("post_rst_starve", 32'(starve_err), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
